// File: rtl/axil_cmd_master.sv
// AXI4-Lite initiator: one command in, one AXI-Lite transaction out, one response back.
// Only one transaction is in flight at a time. The response stays held until it is consumed.
module axil_cmd_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_tvalid,
    output logic                  cmd_tready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_tvalid,
    input  logic                  rsp_tready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [7:0]            err_count,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic [7:0]            err_q, err_d;
    logic                  cap;
    logic [1:0]            cap_resp;

    assign cmd_tready = (state_q == IDLE) && resetn;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        err_d       = err_q;
        cap         = 1'b0;
        cap_resp    = 2'b00;

        unique case (state_q)
            IDLE: begin
                if (cmd_tvalid && cmd_tready) begin
                    addr_d = cmd_addr;
                    if (cmd_write) begin
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_ADDR_DATA;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR_ADDR_DATA: begin
                // AW and W complete independently; a channel already done counts as done.
                if (awvalid_q && m_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_wready)   wvalid_d  = 1'b0;
                if ((!awvalid_q || m_awready) && (!wvalid_q || m_wready)) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = m_bresp;
                    rsp_rdata_d = '0;
                    rsp_write_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    cap         = 1'b1;
                    cap_resp    = m_bresp;
                    state_d     = RSP;
                end
            end
            RD_ADDR: begin
                if (arvalid_q && m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_resp_d  = m_rresp;
                    rsp_rdata_d = m_rdata;
                    rsp_write_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    cap         = 1'b1;
                    cap_resp    = m_rresp;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_tready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cap && (cap_resp != 2'b00) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
            err_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            err_q       <= err_d;
        end
    end

    assign m_awaddr   = addr_q;
    assign m_araddr   = addr_q;
    assign m_wdata    = wdata_q;
    assign m_awvalid  = awvalid_q;
    assign m_wvalid   = wvalid_q;
    assign m_bready   = bready_q;
    assign m_arvalid  = arvalid_q;
    assign m_rready   = rready_q;
    assign rsp_tvalid = rsp_valid_q;
    assign rsp_write  = rsp_write_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_resp   = rsp_resp_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: delay-programmable AXI-Lite slave, protocol monitor,
// and a per-command reference model of the expected response and error count.
module tb_axil_cmd_master;
    logic        clk, resetn;
    logic        cmd_tvalid, cmd_tready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_tvalid, rsp_tready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  err_count;
    logic [7:0]  m_awaddr, m_araddr;
    logic        m_awvalid, m_awready, m_wvalid, m_wready;
    logic [31:0] m_wdata, m_rdata;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

    axil_cmd_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // slave configuration, set by the main sequence before each command
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  cur_bresp = 2'b00, cur_rresp = 2'b00;
    logic [31:0] cur_rdata = 32'h0;

    // monitor: handshake flags, beat counters, protocol rules
    logic        aw_hs_f, w_hs_f, b_hs_f, ar_hs_f, r_hs_f;
    logic        p_awv, p_wv, p_arv, p_br, p_rr;
    logic [7:0]  p_awaddr, p_araddr;
    logic [31:0] p_wdata;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    logic [7:0]  last_awaddr = 8'h0, last_araddr = 8'h0;
    logic [31:0] last_wdata = 32'h0;

    always @(posedge clk) begin
        if (!resetn) begin
            aw_hs_f <= 1'b0; w_hs_f <= 1'b0; b_hs_f <= 1'b0; ar_hs_f <= 1'b0; r_hs_f <= 1'b0;
            p_awv <= 1'b0; p_wv <= 1'b0; p_arv <= 1'b0; p_br <= 1'b0; p_rr <= 1'b0;
            p_awaddr <= 8'h0; p_araddr <= 8'h0; p_wdata <= 32'h0;
        end else begin
            if (p_awv && !aw_hs_f) begin
                chk("aw_hold", 32'(m_awvalid), 1);
                chk("aw_addr_stable", 32'(m_awaddr), 32'(p_awaddr));
            end
            if (aw_hs_f) chk("aw_drop", 32'(m_awvalid), 0);
            if (p_wv && !w_hs_f) begin
                chk("w_hold", 32'(m_wvalid), 1);
                chk("w_data_stable", m_wdata, p_wdata);
            end
            if (w_hs_f) chk("w_drop", 32'(m_wvalid), 0);
            if (p_arv && !ar_hs_f) begin
                chk("ar_hold", 32'(m_arvalid), 1);
                chk("ar_addr_stable", 32'(m_araddr), 32'(p_araddr));
            end
            if (ar_hs_f) chk("ar_drop", 32'(m_arvalid), 0);
            if (p_br && !b_hs_f) chk("bready_hold", 32'(m_bready), 1);
            if (p_rr && !r_hs_f) chk("rready_hold", 32'(m_rready), 1);

            aw_hs_f <= m_awvalid && m_awready;
            w_hs_f  <= m_wvalid && m_wready;
            b_hs_f  <= m_bvalid && m_bready;
            ar_hs_f <= m_arvalid && m_arready;
            r_hs_f  <= m_rvalid && m_rready;
            p_awv <= m_awvalid; p_wv <= m_wvalid; p_arv <= m_arvalid;
            p_br <= m_bready; p_rr <= m_rready;
            p_awaddr <= m_awaddr; p_araddr <= m_araddr; p_wdata <= m_wdata;
            if (m_awvalid && m_awready) begin aw_cnt <= aw_cnt + 1; last_awaddr <= m_awaddr; end
            if (m_wvalid && m_wready)   begin w_cnt <= w_cnt + 1;   last_wdata <= m_wdata;   end
            if (m_bvalid && m_bready)   b_cnt <= b_cnt + 1;
            if (m_arvalid && m_arready) begin ar_cnt <= ar_cnt + 1; last_araddr <= m_araddr; end
            if (m_rvalid && m_rready)   r_cnt <= r_cnt + 1;
        end
    end

    // registered slave: ready rises (dly+1) cycles after valid is first seen,
    // response valid rises dly cycles after the last request beat
    int aw_seen, w_seen, ar_seen, b_seen, r_seen;
    bit aw_got, w_got, ar_got;
    initial begin
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        aw_seen = 0; w_seen = 0; ar_seen = 0; b_seen = 0; r_seen = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
                aw_seen = 0; w_seen = 0; ar_seen = 0; b_seen = 0; r_seen = 0;
                aw_got = 0; w_got = 0; ar_got = 0;
            end else begin
                if (aw_hs_f) begin m_awready = 0; aw_got = 1; aw_seen = 0; end
                else if (m_awvalid && !m_awready) begin
                    if (aw_seen >= aw_dly + 1) m_awready = 1; else aw_seen++;
                end
                if (w_hs_f) begin m_wready = 0; w_got = 1; w_seen = 0; end
                else if (m_wvalid && !m_wready) begin
                    if (w_seen >= w_dly + 1) m_wready = 1; else w_seen++;
                end
                if (b_hs_f) m_bvalid = 0;
                else if (aw_got && w_got && !m_bvalid) begin
                    if (b_seen >= b_dly) begin
                        m_bvalid = 1; m_bresp = cur_bresp; aw_got = 0; w_got = 0; b_seen = 0;
                    end else b_seen++;
                end
                if (ar_hs_f) begin m_arready = 0; ar_got = 1; ar_seen = 0; end
                else if (m_arvalid && !m_arready) begin
                    if (ar_seen >= ar_dly + 1) m_arready = 1; else ar_seen++;
                end
                if (r_hs_f) m_rvalid = 0;
                else if (ar_got && !m_rvalid) begin
                    if (r_seen >= r_dly) begin
                        m_rvalid = 1; m_rdata = cur_rdata; m_rresp = cur_rresp; ar_got = 0; r_seen = 0;
                    end else r_seen++;
                end
            end
        end
    end

    // reference model state
    int          exp_aw = 0, exp_w = 0, exp_b = 0, exp_ar = 0, exp_r = 0, exp_err = 0;
    logic [7:0]  exp_addr = 8'h0;
    logic [31:0] exp_mwdata = 32'h0;

    task automatic run_cmd(input logic wr, input logic [7:0] a, input logic [31:0] d,
                           input int hold, input logic keep, output int lat);
        logic [31:0] e_rdata;
        logic [1:0]  e_resp;
        int n;
        e_rdata = wr ? 32'h0 : cur_rdata;
        e_resp  = wr ? cur_bresp : cur_rresp;
        lat = 0;
        @(negedge clk);
        cmd_tvalid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        n = 0;
        while (!cmd_tready && n < 50) begin @(negedge clk); n++; end
        if (!cmd_tready) begin chk("cmd_accept_timeout", 0, 1); cmd_tvalid = 0; return; end
        @(posedge clk);
        exp_addr = a;
        if (wr) begin exp_mwdata = d; exp_aw++; exp_w++; exp_b++; end
        else begin exp_ar++; exp_r++; end
        if (e_resp != 2'b00 && exp_err < 255) exp_err++;
        @(negedge clk);
        if (!keep) begin cmd_tvalid = 0; cmd_wdata = $urandom; end
        lat = 1;
        while (!rsp_tvalid && lat < 100) begin
            if (keep) chk("busy_tready_low", 32'(cmd_tready), 0);
            @(negedge clk); lat++;
        end
        if (!rsp_tvalid) begin chk("rsp_timeout", 0, 1); cmd_tvalid = 0; return; end
        for (int i = 0; i <= hold; i++) begin
            chk("rsp_tvalid", 32'(rsp_tvalid), 1);
            chk("rsp_write", 32'(rsp_write), 32'(wr));
            chk("rsp_rdata", rsp_rdata, e_rdata);
            chk("rsp_resp", 32'(rsp_resp), 32'(e_resp));
            chk("err_count", 32'(err_count), exp_err);
            chk("rsp_tready_low", 32'(cmd_tready), 0);
            if (i < hold) @(negedge clk);
        end
        rsp_tready = 1;
        @(posedge clk);
        @(negedge clk);
        rsp_tready = 0; cmd_tvalid = 0;
        chk("rsp_drop", 32'(rsp_tvalid), 0);
        chk("idle_tready", 32'(cmd_tready), 1);
        chk("m_awaddr", 32'(m_awaddr), 32'(exp_addr));
        chk("m_araddr", 32'(m_araddr), 32'(exp_addr));
        chk("m_wdata", m_wdata, exp_mwdata);
        chk("aw_beats", aw_cnt, exp_aw);
        chk("w_beats", w_cnt, exp_w);
        chk("b_beats", b_cnt, exp_b);
        chk("ar_beats", ar_cnt, exp_ar);
        chk("r_beats", r_cnt, exp_r);
        if (wr) begin
            chk("aw_beat_addr", 32'(last_awaddr), 32'(a));
            chk("w_beat_data", last_wdata, d);
        end else chk("ar_beat_addr", 32'(last_araddr), 32'(a));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n;
        resetn = 0; cmd_tvalid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_tready = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_tready", 32'(cmd_tready), 0);
        chk("rst_awvalid", 32'(m_awvalid), 0);
        chk("rst_wvalid", 32'(m_wvalid), 0);
        chk("rst_arvalid", 32'(m_arvalid), 0);
        chk("rst_bready", 32'(m_bready), 0);
        chk("rst_rready", 32'(m_rready), 0);
        chk("rst_rsp_tvalid", 32'(rsp_tvalid), 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_awaddr", 32'(m_awaddr), 0);
        chk("rst_wdata", m_wdata, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_resp", 32'(rsp_resp), 0);
        resetn = 1;
        #1 chk("post_rst_tready", 32'(cmd_tready), 1);

        // zero-wait write and read
        run_cmd(1, 8'h0C, 32'hDEADBEEF, 0, 0, lat);
        chk("wr_latency", lat, 4);
        cur_rdata = 32'h1234_5678;
        run_cmd(0, 8'h20, 32'hCAFE_0000, 0, 0, lat);
        chk("rd_latency", lat, 4);

        // read with rvalid three cycles late
        r_dly = 3; cur_rdata = 32'h0000_0055;
        run_cmd(0, 8'h10, 32'h0, 0, 0, lat);
        chk("rd_slow_latency", lat, 7);
        r_dly = 0;

        // skewed write channels, both orders
        aw_dly = 0; w_dly = 5;
        run_cmd(1, 8'h44, 32'hA5A5_0001, 0, 0, lat);
        chk("wr_w_late_latency", lat, 9);
        aw_dly = 5; w_dly = 0;
        run_cmd(1, 8'h48, 32'h5A5A_0002, 0, 0, lat);
        chk("wr_aw_late_latency", lat, 9);
        aw_dly = 0;

        // response backpressure with cmd_tvalid held high
        cur_bresp = 2'b00;
        run_cmd(1, 8'h30, 32'h0BAD_F00D, 10, 1, lat);

        // randomized commands and slave timing
        for (int t = 0; t < 40; t++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            cur_bresp = 2'($urandom); cur_rresp = 2'($urandom); cur_rdata = $urandom;
            run_cmd(1'($urandom), 8'($urandom), $urandom, $urandom_range(0, 3), 0, lat);
        end
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;

        // SLVERR on 300 reads saturates the error counter
        cur_rresp = 2'b10;
        for (int t = 0; t < 300; t++) begin
            cur_rdata = $urandom;
            run_cmd(0, 8'($urandom), $urandom, 0, 0, lat);
        end
        chk("err_saturated", 32'(err_count), 255);
        cur_rresp = 2'b00;

        // reset while W is still pending after AW completed
        w_dly = 6;
        @(negedge clk);
        cmd_tvalid = 1; cmd_write = 1; cmd_addr = 8'h3C; cmd_wdata = 32'h7777_8888;
        @(posedge clk);
        @(negedge clk);
        cmd_tvalid = 0;
        n = 0;
        while (!(m_wvalid && !m_awvalid) && n < 20) begin @(negedge clk); n++; end
        chk("rst_mid_reached", 32'(m_wvalid && !m_awvalid), 1);
        exp_aw++;
        #2 resetn = 0;
        #1;
        chk("async_awvalid", 32'(m_awvalid), 0);
        chk("async_wvalid", 32'(m_wvalid), 0);
        chk("async_arvalid", 32'(m_arvalid), 0);
        chk("async_bready", 32'(m_bready), 0);
        chk("async_rready", 32'(m_rready), 0);
        chk("async_rsp_tvalid", 32'(rsp_tvalid), 0);
        chk("async_cmd_tready", 32'(cmd_tready), 0);
        chk("async_err_count", 32'(err_count), 0);
        exp_err = 0; exp_mwdata = 32'h0; exp_addr = 8'h0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1; w_dly = 0;
        #1;
        chk("rel_cmd_tready", 32'(cmd_tready), 1);
        chk("rel_err_count", 32'(err_count), 0);
        chk("rel_wvalid", 32'(m_wvalid), 0);
        chk("rel_wdata", m_wdata, 0);

        // normal operation after reset
        cur_bresp = 2'b01;
        run_cmd(1, 8'hF0, 32'h1357_9BDF, 1, 0, lat);
        chk("post_rst_wr_latency", lat, 4);
        cur_rresp = 2'b00; cur_rdata = 32'h2468_ACE0;
        run_cmd(0, 8'hF4, 32'hFFFF_FFFF, 0, 0, lat);
        chk("post_rst_rd_latency", lat, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
